seq_alu_mul: RTL and testbench
==============================

// Module: seq_alu_mul
// PURPOSE
//  Parametrised, registered successor to the 4-bit 74181-style ALU: the same 16 logic / 16 arithmetic functions (M/S coding),
//  generalised to WIDTH bits, with valid/ready handshakes on input and output, and an optional multi-cycle shift-add multiply.
//  Sits between the operand/control sequencer and the result register file of the shift-add-multiplier datapath.
// PARAMETERS
//  WIDTH    8   operand/result width in bits (>=2)
//  CNT_W    $clog2(WIDTH+1)   multiply step-counter width (derived; not intended for override)
// PORTS
//  clk        in   1        single clock, all state updates on rising edge
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        operands/opcode valid
//  in_ready   out  1        block can accept an operation this cycle
//  a          in   WIDTH    operand A
//  b          in   WIDTH    operand B
//  s          in   4        function select (74181 coding)
//  m          in   1        1 = logic mode, 0 = arithmetic mode
//  c_in       in   1        carry in (arithmetic mode; adds 1)
//  mul_sel    in   1        1 = unsigned multiply A*B (only with SEQ_ALU_MUL_EN)
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer accepts result
//  f          out  WIDTH    result (low half of product for multiply)
//  f_hi       out  WIDTH    high half of product; 0 for all non-multiply ops
//  c_out      out  1        carry out (arithmetic only; 0 for logic and multiply)
//  a_eq_b     out  1        captured A == captured B
//  zero       out  1        result == 0 (full 2*WIDTH product for multiply)
// BEHAVIOUR
//  - Reset: state IDLE; out_valid=0; f, f_hi, c_out, a_eq_b, zero = 0; in_ready=1 on the cycle after reset deasserts.
//  - in_ready = (state==IDLE) && (!out_valid || out_ready). Transfer on in_valid && in_ready; operands captured that edge.
//  - Logic mode (m=1): 0000 ~A, 0001 ~(A|B), 0010 ~A&B, 0011 0, 0100 ~(A&B), 0101 ~B, 0110 A^B, 0111 A&~B, 1000 ~A|B,
//    1001 ~(A^B), 1010 B, 1011 A&B, 1100 all-ones, 1101 A|~B, 1110 A|B, 1111 A. c_in ignored; c_out=0.
//  - Arith mode (m=0), computed in WIDTH+1 bits, operands zero-extended, "-1" added as {1'b0,all-ones}, then +c_in:
//    0000 A; 0001 A|B; 0010 A|~B; 0011 -1; 0100 A+(A&~B); 0101 (A|B)+(A&~B); 0110 A+~B (A-B-1); 0111 (A&~B)-1;
//    1000 A+(A&B); 1001 A+B; 1010 (A|~B)+(A&B); 1011 (A&B)-1; 1100 A+A; 1101 (A|B)+A; 1110 (A|~B)+A; 1111 A-1.
//    f = sum[WIDTH-1:0]; c_out = sum[WIDTH]. Sum wider than WIDTH+1 impossible; no saturation.
//  - ALU op latency: out_valid rises the cycle after transfer (1 cycle).
//  - Multiply: IDLE -> MUL on transfer with mul_sel=1. Each MUL cycle: if multiplier LSB, acc_hi += multiplicand (WIDTH+1
//    bits); {acc_hi,acc_lo} shifted right 1. After exactly WIDTH MUL cycles -> IDLE, out_valid=1 with {f_hi,f}=A*B.
//    Latency WIDTH+1 cycles from transfer to out_valid. in_ready=0 throughout MUL.
//  - Output hold: while out_valid && !out_ready all outputs stay stable. out_valid drops after out_ready unless a new
//    result is loaded the same edge (back-to-back ALU ops sustain 1 op/cycle).
//  - in_valid during MUL or blocked output: ignored, no capture. rst mid-MUL: operation aborted, no result emitted.
//  - a_eq_b and zero are registered with the result, not combinational from live inputs.
// CONFIGURATION
//  SEQ_ALU_MUL_EN defined: multiply path, MUL state and step counter present as above.
//  SEQ_ALU_MUL_EN undefined: mul_sel ignored (op executes per m/s), f_hi tied 0, FSM reduced to IDLE; no multi-cycle path.
// STRUCTURE
//  - Package seq_alu_pkg: state enum (IDLE, MUL), logic/arith s-code localparams, mode constants (MODE_LOGIC, MODE_ARITH).
//  - Sub-module alu_core #(WIDTH): purely combinational m/s function unit returning {c_out,f}; also reused for the
//    multiply accumulate add (s=1001, m=0). seq_alu_mul owns handshake, FSM, counter and output registers.
// TESTING (WIDTH=8)
//  - rst held 2 cycles then released -> out_valid=0, f=0, f_hi=0, flags 0; in_ready=1.
//  - m=0 s=1001 a=0xF0 b=0x20 c_in=1 -> next cycle f=0x11 c_out=1 zero=0; a=0x00 s=1111 c_in=0 -> f=0xFF c_out=0.
//  - m=1 sweep all 16 s with a=0xC3 b=0x5A -> f matches table (e.g. s=0110 f=0x99, s=1011 f=0x42); c_out=0.
//  - mul_sel=1 a=0xFF b=0xFF -> in_ready=0 for 8 cycles, out_valid on cycle 9, {f_hi,f}=0xFE01; a=0 -> zero=1.
//  - out_ready=0 for 5 cycles with result pending -> outputs stable, in_ready=0; back-to-back ALU ops with out_ready=1
//    -> one result per cycle, no loss.
//  - rst asserted at MUL step 4 -> no out_valid; next op a=3 b=5 mul -> 15; without SEQ_ALU_MUL_EN mul_sel ignored, f_hi=0.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared types and constants for the registered 74181-style ALU with
// optional shift-add multiply (seq_alu_mul).
package seq_alu_pkg;

  // Control FSM states; MUL is only reachable when SEQ_ALU_MUL_EN is defined.
  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  // m input coding
  localparam logic MODE_ARITH = 1'b0;
  localparam logic MODE_LOGIC = 1'b1;

  // Logic-mode (m=1) function codes
  localparam logic [3:0] LS_NOT_A     = 4'h0, LS_NOR       = 4'h1, LS_NOTA_AND_B = 4'h2, LS_ZERO     = 4'h3;
  localparam logic [3:0] LS_NAND      = 4'h4, LS_NOT_B     = 4'h5, LS_XOR        = 4'h6, LS_A_ANDN_B = 4'h7;
  localparam logic [3:0] LS_NOTA_OR_B = 4'h8, LS_XNOR      = 4'h9, LS_B          = 4'hA, LS_AND      = 4'hB;
  localparam logic [3:0] LS_ONES      = 4'hC, LS_A_ORN_B   = 4'hD, LS_OR         = 4'hE, LS_A        = 4'hF;

  // Arithmetic-mode (m=0) function codes (all results additionally +c_in)
  localparam logic [3:0] AS_A          = 4'h0, AS_OR           = 4'h1, AS_ORN           = 4'h2, AS_MINUS1     = 4'h3;
  localparam logic [3:0] AS_A_PLUS_ANB = 4'h4, AS_OR_PLUS_ANB  = 4'h5, AS_SUB           = 4'h6, AS_ANB_MINUS1 = 4'h7;
  localparam logic [3:0] AS_A_PLUS_AND = 4'h8, AS_ADD          = 4'h9, AS_ORN_PLUS_AND  = 4'hA, AS_AND_MINUS1 = 4'hB;
  localparam logic [3:0] AS_DOUBLE     = 4'hC, AS_OR_PLUS_A    = 4'hD, AS_ORN_PLUS_A    = 4'hE, AS_DEC        = 4'hF;

endpackage

// File: rtl/seq_alu_mul_alu_core.sv
// alu_core: purely combinational 74181-style function unit generalised to
// WIDTH bits. Returns {c_out_o, f_o}; c_out_o is always 0 in logic mode.
module alu_core
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       s_i,
  input  logic             m_i,
  input  logic             c_in_i,
  output logic [WIDTH-1:0] f_o,
  output logic             c_out_o
);

  // "-1" is added as a zero-extended all-ones word so the carry out behaves
  // like the original part (borrow shows up as c_out=0).
  localparam logic [WIDTH:0] ONES_X = {1'b0, {WIDTH{1'b1}}};

  logic [WIDTH:0]   ax, bx, nbx;
  logic [WIDTH:0]   x, y, sum;
  logic [WIDTH-1:0] f_logic;

  assign ax  = {1'b0, a_i};
  assign bx  = {1'b0, b_i};
  assign nbx = {1'b0, ~b_i};

  // Select logic result and the two arithmetic addends, then sum with carry-in
  always_comb begin
    f_logic = '0;
    x       = '0;
    y       = '0;
    case (s_i)
      LS_NOT_A:      f_logic = ~a_i;
      LS_NOR:        f_logic = ~(a_i | b_i);
      LS_NOTA_AND_B: f_logic = ~a_i & b_i;
      LS_ZERO:       f_logic = '0;
      LS_NAND:       f_logic = ~(a_i & b_i);
      LS_NOT_B:      f_logic = ~b_i;
      LS_XOR:        f_logic = a_i ^ b_i;
      LS_A_ANDN_B:   f_logic = a_i & ~b_i;
      LS_NOTA_OR_B:  f_logic = ~a_i | b_i;
      LS_XNOR:       f_logic = ~(a_i ^ b_i);
      LS_B:          f_logic = b_i;
      LS_AND:        f_logic = a_i & b_i;
      LS_ONES:       f_logic = '1;
      LS_A_ORN_B:    f_logic = a_i | ~b_i;
      LS_OR:         f_logic = a_i | b_i;
      default:       f_logic = a_i;
    endcase
    case (s_i)
      AS_A:          begin x = ax;          y = '0;          end
      AS_OR:         begin x = ax | bx;     y = '0;          end
      AS_ORN:        begin x = ax | nbx;    y = '0;          end
      AS_MINUS1:     begin x = '0;          y = ONES_X;      end
      AS_A_PLUS_ANB: begin x = ax;          y = ax & nbx;    end
      AS_OR_PLUS_ANB:begin x = ax | bx;     y = ax & nbx;    end
      AS_SUB:        begin x = ax;          y = nbx;         end
      AS_ANB_MINUS1: begin x = ax & nbx;    y = ONES_X;      end
      AS_A_PLUS_AND: begin x = ax;          y = ax & bx;     end
      AS_ADD:        begin x = ax;          y = bx;          end
      AS_ORN_PLUS_AND:begin x = ax | nbx;   y = ax & bx;     end
      AS_AND_MINUS1: begin x = ax & bx;     y = ONES_X;      end
      AS_DOUBLE:     begin x = ax;          y = ax;          end
      AS_OR_PLUS_A:  begin x = ax | bx;     y = ax;          end
      AS_ORN_PLUS_A: begin x = ax | nbx;    y = ax;          end
      default:       begin x = ax;          y = ONES_X;      end
    endcase
    sum = x + y + {{WIDTH{1'b0}}, c_in_i};
  end

  assign f_o     = (m_i == MODE_LOGIC) ? f_logic : sum[WIDTH-1:0];
  assign c_out_o = (m_i == MODE_LOGIC) ? 1'b0    : sum[WIDTH];

endmodule

// File: rtl/seq_alu_mul.sv
// seq_alu_mul: registered 74181-style ALU with valid/ready handshakes.
// Optional multi-cycle unsigned shift-add multiply enabled by SEQ_ALU_MUL_EN.
//
// Handshake: an operation transfers on in_valid && in_ready; a result is
// consumed on out_valid && out_ready. in_ready is only high in IDLE with the
// output register empty or being drained this cycle, so a new result never
// overwrites one that has not been accepted. While out_valid && !out_ready
// all result outputs hold.
module seq_alu_mul
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             c_in,
  input  logic             mul_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] f_hi,
  output logic             c_out,
  output logic             a_eq_b,
  output logic             zero,
  output state_e           dbg_state
);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] f_q, f_d, f_hi_q, f_hi_d;
  logic             c_out_q, c_out_d, a_eq_b_q, a_eq_b_d, zero_q, zero_d;

  logic             xfer, alu_load;
  logic [WIDTH-1:0] alu_f;
  logic             alu_c;

  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign xfer     = in_valid && in_ready;

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .a_i    (a),
    .b_i    (b),
    .s_i    (s),
    .m_i    (m),
    .c_in_i (c_in),
    .f_o    (alu_f),
    .c_out_o(alu_c)
  );

`ifdef SEQ_ALU_MUL_EN
  logic             start_mul, mul_done;
  logic [WIDTH-1:0] mcand_q, acc_hi_q, acc_lo_q, acc_hi_d, acc_lo_d;
  logic [CNT_W-1:0] cnt_q;
  logic             eq_q;
  logic [WIDTH-1:0] mac_f;
  logic             mac_c;

  assign start_mul = xfer && mul_sel;
  assign alu_load  = xfer && !mul_sel;
  assign mul_done  = (state_q == MUL) && (cnt_q == CNT_W'(WIDTH - 1));

  // Accumulate step: acc_hi + (multiplier LSB ? multiplicand : 0), WIDTH+1 bits
  alu_core #(.WIDTH(WIDTH)) u_mac (
    .a_i    (acc_hi_q),
    .b_i    (acc_lo_q[0] ? mcand_q : '0),
    .s_i    (AS_ADD),
    .m_i    (MODE_ARITH),
    .c_in_i (1'b0),
    .f_o    (mac_f),
    .c_out_o(mac_c)
  );

  // {carry, sum, acc_lo} shifted right one place
  assign acc_hi_d = {mac_c, mac_f[WIDTH-1:1]};
  assign acc_lo_d = {mac_f[0], acc_lo_q[WIDTH-1:1]};

  // Multiply datapath: load operands on transfer, step once per MUL cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
      eq_q     <= 1'b0;
    end else if (start_mul) begin
      mcand_q  <= a;
      acc_hi_q <= '0;
      acc_lo_q <= b;
      cnt_q    <= '0;
      eq_q     <= (a == b);
    end else if (state_q == MUL) begin
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      cnt_q    <= cnt_q + 1'b1;
    end
  end

  // Next state: IDLE -> MUL on multiply transfer, back after WIDTH steps
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_mul) state_d = MUL;
      MUL:     if (mul_done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
`else
  logic             unused_mul_sel;
  logic [CNT_W-1:0] unused_cnt;

  assign unused_mul_sel = mul_sel;
  assign unused_cnt     = '0;
  assign alu_load       = xfer;

  // Without the multiplier the FSM never leaves IDLE
  always_comb begin
    state_d = IDLE;
  end
`endif

  // Output register next values: hold, drain on out_ready, or load a result
  always_comb begin
    out_valid_d = out_valid_q;
    f_d         = f_q;
    f_hi_d      = f_hi_q;
    c_out_d     = c_out_q;
    a_eq_b_d    = a_eq_b_q;
    zero_d      = zero_q;
    if (out_ready) out_valid_d = 1'b0;
    if (alu_load) begin
      out_valid_d = 1'b1;
      f_d         = alu_f;
      f_hi_d      = '0;
      c_out_d     = alu_c;
      a_eq_b_d    = (a == b);
      zero_d      = (alu_f == '0);
    end
`ifdef SEQ_ALU_MUL_EN
    if (mul_done) begin
      out_valid_d = 1'b1;
      f_d         = acc_lo_d;
      f_hi_d      = acc_hi_d;
      c_out_d     = 1'b0;
      a_eq_b_d    = eq_q;
      zero_d      = ({acc_hi_d, acc_lo_d} == '0);
    end
`endif
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      f_q         <= '0;
      f_hi_q      <= '0;
      c_out_q     <= 1'b0;
      a_eq_b_q    <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      f_q         <= f_d;
      f_hi_q      <= f_hi_d;
      c_out_q     <= c_out_d;
      a_eq_b_q    <= a_eq_b_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign f         = f_q;
  assign f_hi      = f_hi_q;
  assign c_out     = c_out_q;
  assign a_eq_b    = a_eq_b_q;
  assign zero      = zero_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_alu_mul.sv
// Directed testbench for seq_alu_mul (WIDTH=8). Multiply checks are built
// when SEQ_ALU_MUL_EN is defined; otherwise mul_sel is checked to be ignored.
module tb_seq_alu_mul;
  import seq_alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b;
  logic [3:0]   s;
  logic         m, c_in, mul_sel;
  logic         out_valid, out_ready;
  logic [W-1:0] f, f_hi;
  logic         c_out, a_eq_b, zero;
  state_e       dbg_state;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] exp_q[$];

  seq_alu_mul #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .s        (s),
    .m        (m),
    .c_in     (c_in),
    .mul_sel  (mul_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .f        (f),
    .f_hi     (f_hi),
    .c_out    (c_out),
    .a_eq_b   (a_eq_b),
    .zero     (zero),
    .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Hard time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_op(input logic mm, input logic [3:0] ss, input logic [W-1:0] aa,
                          input logic [W-1:0] bb, input logic cc, input logic ms);
    m = mm; s = ss; a = aa; b = bb; c_in = cc; mul_sel = ms; in_valid = 1'b1;
  endtask

  // One ALU op with out_ready=1, result expected the cycle after transfer
  task automatic run_alu(input string tag, input logic mm, input logic [3:0] ss,
                         input logic [W-1:0] aa, input logic [W-1:0] bb, input logic cc,
                         input logic [W-1:0] ef, input logic ec, input logic ez, input logic eq);
    @(negedge clk);
    check({tag, "_rdy"}, in_ready, 1);
    drive_op(mm, ss, aa, bb, cc, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_v"}, out_valid, 1);
    check({tag, "_f"}, f, ef);
    check({tag, "_fhi"}, f_hi, 0);
    check({tag, "_c"}, c_out, ec);
    check({tag, "_z"}, zero, ez);
    check({tag, "_eq"}, a_eq_b, eq);
  endtask

  task automatic wait_out(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  logic [W-1:0] logic_exp [16];
  bit           ok;
  bit           saw_valid;
  int           n_rx;

  initial begin
    logic_exp = '{8'h3C, 8'h24, 8'h18, 8'h00, 8'hBD, 8'hA5, 8'h99, 8'h81,
                  8'h7E, 8'h66, 8'h5A, 8'h42, 8'hFF, 8'hE7, 8'hDB, 8'hC3};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; s = '0; m = 1'b0; c_in = 1'b0; mul_sel = 1'b0;

    // Reset held two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_f", f, 0);
    check("rst_f_hi", f_hi, 0);
    check("rst_c_out", c_out, 0);
    check("rst_a_eq_b", a_eq_b, 0);
    check("rst_zero", zero, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_state", dbg_state, IDLE);

    // Arithmetic vectors
    run_alu("add_c",  MODE_ARITH, 4'b1001, 8'hF0, 8'h20, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
    run_alu("dec0",   MODE_ARITH, 4'b1111, 8'h00, 8'h20, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
    run_alu("sub",    MODE_ARITH, 4'b0110, 8'hC3, 8'h5A, 1'b0, 8'h68, 1'b1, 1'b0, 1'b0);
    run_alu("dbl",    MODE_ARITH, 4'b1100, 8'hC3, 8'h5A, 1'b0, 8'h86, 1'b1, 1'b0, 1'b0);
    run_alu("m1_cin", MODE_ARITH, 4'b0011, 8'hC3, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    run_alu("a_cin",  MODE_ARITH, 4'b0000, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);

    // Logic sweep; c_in=1 must not matter
    for (int i = 0; i < 16; i++) begin
      run_alu($sformatf("log_s%0d", i), MODE_LOGIC, 4'(i), 8'hC3, 8'h5A, 1'b1,
              logic_exp[i], 1'b0, (logic_exp[i] == 8'h00), 1'b0);
    end

`ifdef SEQ_ALU_MUL_EN
    // 0xFF * 0xFF: 8 busy cycles, result on the 9th
    @(negedge clk);
    drive_op(MODE_ARITH, 4'b0000, 8'hFF, 8'hFF, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("mul_busy_rdy%0d", i), in_ready, 0);
      check($sformatf("mul_busy_v%0d", i), out_valid, 0);
      check($sformatf("mul_busy_st%0d", i), dbg_state, MUL);
    end
    @(negedge clk);
    check("mul_ff_v", out_valid, 1);
    check("mul_ff_f", f, 8'h01);
    check("mul_ff_fhi", f_hi, 8'hFE);
    check("mul_ff_c", c_out, 0);
    check("mul_ff_z", zero, 0);
    check("mul_ff_eq", a_eq_b, 1);
`else
    // mul_sel has no effect: plain single-cycle add, f_hi stays 0
    run_alu("musel_ign", MODE_ARITH, 4'b1001, 8'h03, 8'h05, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive_op(MODE_ARITH, 4'b1001, 8'hFF, 8'h02, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check("musel_v", out_valid, 1);
    check("musel_f", f, 8'h01);
    check("musel_fhi", f_hi, 0);
    check("musel_c", c_out, 1);
`endif

    // Equality flag and f_hi cleared by a following ALU op
    run_alu("eq", MODE_ARITH, 4'b1001, 8'h5A, 8'h5A, 1'b0, 8'hB4, 1'b0, 1'b0, 1'b1);

    // Output hold with out_ready low; new in_valid must be ignored
    @(negedge clk);
    out_ready = 1'b0;
    drive_op(MODE_ARITH, 4'b1001, 8'h33, 8'h44, 1'b0, 1'b0);
    @(negedge clk);
    drive_op(MODE_LOGIC, 4'b1100, 8'h01, 8'h01, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold_v%0d", i), out_valid, 1);
      check($sformatf("hold_f%0d", i), f, 8'h77);
      check($sformatf("hold_rdy%0d", i), in_ready, 0);
      check($sformatf("hold_eq%0d", i), a_eq_b, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("hold_drop_v", out_valid, 0);
    check("hold_keep_f", f, 8'h77);

    // Back-to-back ALU ops, one per cycle, scoreboarded
    n_rx = 0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      if (out_valid) begin
        check($sformatf("b2b_f%0d", n_rx), f, exp_q.pop_front());
        n_rx++;
      end
      check($sformatf("b2b_rdy%0d", i), in_ready, 1);
      drive_op(MODE_ARITH, 4'b1001, 8'(i * 17), 8'h10, 1'b0, 1'b0);
      exp_q.push_back(8'(i * 17 + 16));
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (out_valid) begin
      check($sformatf("b2b_f%0d", n_rx), f, exp_q.pop_front());
      n_rx++;
    end
    check("b2b_count", n_rx, 6);
    check("b2b_q_empty", exp_q.size(), 0);
    @(negedge clk);
    check("b2b_idle_v", out_valid, 0);

`ifdef SEQ_ALU_MUL_EN
    // Reset in the middle of a multiply: no result may appear
    drive_op(MODE_ARITH, 4'b0000, 8'h12, 8'h34, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("abort_no_v", saw_valid, 0);
    check("abort_rdy", in_ready, 1);
    check("abort_state", dbg_state, IDLE);

    // 3 * 5 = 15
    drive_op(MODE_ARITH, 4'b0000, 8'h03, 8'h05, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(20, ok);
    check("mul35_to", ok, 1);
    check("mul35_f", f, 8'h0F);
    check("mul35_fhi", f_hi, 8'h00);
    check("mul35_z", zero, 0);

    // 0 * 0x77 = 0, zero flag over the full product
    @(negedge clk);
    drive_op(MODE_ARITH, 4'b0000, 8'h00, 8'h77, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(20, ok);
    check("mul0_to", ok, 1);
    check("mul0_f", f, 8'h00);
    check("mul0_fhi", f_hi, 8'h00);
    check("mul0_z", zero, 1);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
